// File: rtl/vx_priority_serializer_pkg.sv
// Shared helpers for the priority serializer: index-width derivation and state encodings.
// No logic; imported by the top and the grant chain.
package vx_priority_serializer_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Index width that stays at least one bit wide for a single-bit mask.
   function automatic int log2up(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_priority_serializer_grant_chain.sv
// Combinational grant chain: LANES cascaded priority encoders, each seeing the request minus earlier grants.
// Zero latency, no state, no backpressure; a pure function of the request mask.
module VX_priority_encoder
   import vx_priority_serializer_pkg::*;
#(
   parameter int N       = 8,
   parameter bit REVERSE = 1'b0,
   parameter int LN      = log2up(N)
) (
   input  logic [N-1:0]  data_in,
   output logic [N-1:0]  onehot_out,
   output logic [LN-1:0] index_out,
   output logic          valid_out
);

   // Later loop iterations overwrite earlier ones, so scan from lowest to highest priority.
   always_comb begin
      onehot_out = '0;
      index_out  = '0;
      valid_out  = |data_in;
      if (REVERSE) begin
         for (int i = 0; i < N; i++) begin
            if (data_in[i]) begin
               onehot_out    = '0;
               onehot_out[i] = 1'b1;
               index_out     = LN'(i);
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (data_in[i]) begin
               onehot_out    = '0;
               onehot_out[i] = 1'b1;
               index_out     = LN'(i);
            end
         end
      end
   end

endmodule

module VX_priority_grant_chain
   import vx_priority_serializer_pkg::*;
#(
   parameter int N       = 8,
   parameter int LANES   = 1,
   parameter bit REVERSE = 1'b0,
   parameter int LN      = log2up(N)
) (
   input  logic [N-1:0]        data_in,
   output logic [LANES-1:0]    lane_valid_out,
   output logic [LANES*LN-1:0] index_out,
   output logic [N-1:0]        onehot_out
);

   genvar k;
   for (k = 0; k < LANES; k++) begin : g_lane
      logic [N-1:0] req;
      logic [N-1:0] oh;
      logic [N-1:0] acc;

      if (k == 0) begin : g_first
         assign req = data_in;
         assign acc = oh;
      end else begin : g_next
         assign req = g_lane[k-1].req & ~g_lane[k-1].oh;
         assign acc = g_lane[k-1].acc | oh;
      end

      VX_priority_encoder #(
         .N       (N),
         .REVERSE (REVERSE),
         .LN      (LN)
      ) u_enc (
         .data_in    (req),
         .onehot_out (oh),
         .index_out  (index_out[k*LN +: LN]),
         .valid_out  (lane_valid_out[k])
      );
   end

   assign onehot_out = g_lane[LANES-1].acc;

endmodule

// File: rtl/vx_priority_serializer.sv
// Expands a request mask into beats of up to LANES priority-ordered bit indices; first beat one cycle after accept.
// Beats hold while ready_out is low; a new mask is taken only when idle or alongside the final beat.
module vx_priority_serializer
   import vx_priority_serializer_pkg::*;
#(
   parameter int N       = 8,
   parameter int LANES   = 1,
   parameter bit REVERSE = 1'b0,
   parameter int TAG_W   = 1,
   parameter int LN      = log2up(N)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_in,
   input  logic [N-1:0]        data_in,
   input  logic [TAG_W-1:0]    tag_in,
   output logic                ready_in,
   output logic                valid_out,
   output logic [LANES-1:0]    lane_valid_out,
   output logic [LANES*LN-1:0] index_out,
   output logic [N-1:0]        onehot_out,
   output logic [TAG_W-1:0]    tag_out,
   output logic                last_out,
   input  logic                ready_out
);

   logic [0:0]       state;
   logic [N-1:0]     rem;
   logic [TAG_W-1:0] tag;
   logic             busy;
   logic             beat_fire;
   logic             accept;

   VX_priority_grant_chain #(
      .N       (N),
      .LANES   (LANES),
      .REVERSE (REVERSE),
      .LN      (LN)
   ) u_chain (
      .data_in        (rem),
      .lane_valid_out (lane_valid_out),
      .index_out      (index_out),
      .onehot_out     (onehot_out)
   );

   assign busy      = (state == ST_BUSY);
   assign valid_out = busy;
   assign tag_out   = tag;
   assign last_out  = ((rem & ~onehot_out) == '0);
   assign beat_fire = busy & ready_out;
   // The final beat frees the slot in the same cycle, so masks stream without a bubble.
   assign ready_in  = ~reset & (~busy | (beat_fire & last_out));
   assign accept    = valid_in & ready_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         rem   <= '0;
         tag   <= '0;
      end else if (accept) begin
         state <= ST_BUSY;
         rem   <= data_in;
         tag   <= tag_in;
      end else if (beat_fire) begin
         rem <= rem & ~onehot_out;
         if (last_out) begin
            state <= ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && busy) begin
         assert ((onehot_out & ~rem) == '0);
         assert ($countones(onehot_out) == $countones(lane_valid_out));
      end
   end

endmodule

// File: tb/tb_vx_priority_serializer.sv
// Bench for vx_priority_serializer: three configurations (1 lane, 2 lanes, 1 lane reversed) with a beat scoreboard.
module tb_vx_priority_serializer;

   typedef struct packed {
      logic [1:0] lv;
      logic [5:0] idx;
      logic [7:0] oh;
      logic [3:0] tag;
      logic       last;
   } beat_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       vin_a, rin_a, vout_a, lvo_a, last_a, rout_a;
   logic [7:0] din_a, oh_a;
   logic [3:0] tin_a, tgo_a;
   logic [2:0] idx_a;

   logic       vin_b, rin_b, vout_b, last_b, rout_b;
   logic [1:0] lvo_b;
   logic [7:0] din_b, oh_b;
   logic [3:0] tin_b, tgo_b;
   logic [5:0] idx_b;

   logic       vin_c, rin_c, vout_c, lvo_c, last_c, rout_c;
   logic [7:0] din_c, oh_c;
   logic [3:0] tin_c, tgo_c;
   logic [2:0] idx_c;

   beat_t q_a[$];
   beat_t q_b[$];
   beat_t q_c[$];
   int n_checks = 0;
   int n_pass   = 0;

   vx_priority_serializer #(.N(8), .LANES(1), .REVERSE(1'b0), .TAG_W(4)) dut_a (
      .clk(clk), .reset(reset), .valid_in(vin_a), .data_in(din_a), .tag_in(tin_a),
      .ready_in(rin_a), .valid_out(vout_a), .lane_valid_out(lvo_a), .index_out(idx_a),
      .onehot_out(oh_a), .tag_out(tgo_a), .last_out(last_a), .ready_out(rout_a));

   vx_priority_serializer #(.N(8), .LANES(2), .REVERSE(1'b0), .TAG_W(4)) dut_b (
      .clk(clk), .reset(reset), .valid_in(vin_b), .data_in(din_b), .tag_in(tin_b),
      .ready_in(rin_b), .valid_out(vout_b), .lane_valid_out(lvo_b), .index_out(idx_b),
      .onehot_out(oh_b), .tag_out(tgo_b), .last_out(last_b), .ready_out(rout_b));

   vx_priority_serializer #(.N(8), .LANES(1), .REVERSE(1'b1), .TAG_W(4)) dut_c (
      .clk(clk), .reset(reset), .valid_in(vin_c), .data_in(din_c), .tag_in(tin_c),
      .ready_in(rin_c), .valid_out(vout_c), .lane_valid_out(lvo_c), .index_out(idx_c),
      .onehot_out(oh_c), .tag_out(tgo_c), .last_out(last_c), .ready_out(rout_c));

   function automatic void enq(input int dut, input beat_t b);
      if (dut == 0) q_a.push_back(b);
      else if (dut == 1) q_b.push_back(b);
      else q_c.push_back(b);
   endfunction

   // Reference model: list set bits in priority order, then chunk them into beats.
   function automatic void push_exp(input int dut, input logic [7:0] m, input logic [3:0] t);
      int    lanes;
      bit    rev;
      int    order[$];
      int    pos;
      beat_t b;
      lanes = (dut == 1) ? 2 : 1;
      rev   = (dut == 2);
      for (int p = 0; p < 8; p++) begin
         pos = rev ? 7 - p : p;
         if (m[pos]) order.push_back(pos);
      end
      if (order.size() == 0) begin
         b = '0; b.tag = t; b.last = 1'b1;
         enq(dut, b);
      end else begin
         for (int s = 0; s < order.size(); s += lanes) begin
            b = '0;
            b.tag = t;
            for (int l = 0; l < lanes; l++) begin
               if (s + l < order.size()) begin
                  b.lv[l]          = 1'b1;
                  b.idx[l*3 +: 3]  = 3'(order[s+l]);
                  b.oh[order[s+l]] = 1'b1;
               end
            end
            b.last = (s + lanes >= order.size());
            enq(dut, b);
         end
      end
   endfunction

   function automatic beat_t obs_a();
      beat_t b = '0;
      b.lv[0] = lvo_a; b.idx[2:0] = idx_a; b.oh = oh_a; b.tag = tgo_a; b.last = last_a;
      return b;
   endfunction

   function automatic beat_t obs_b();
      beat_t b = '0;
      b.lv = lvo_b; b.idx = idx_b; b.oh = oh_b; b.tag = tgo_b; b.last = last_b;
      return b;
   endfunction

   function automatic beat_t obs_c();
      beat_t b = '0;
      b.lv[0] = lvo_c; b.idx[2:0] = idx_c; b.oh = oh_c; b.tag = tgo_c; b.last = last_c;
      return b;
   endfunction

   task automatic test_reset();
      beat_t e;
      e = '0; e.last = 1'b1;
      reset = 1'b1;
      vin_a = 0; din_a = '0; tin_a = '0; rout_a = 1;
      vin_b = 0; din_b = '0; tin_b = '0; rout_b = 1;
      vin_c = 0; din_c = '0; tin_c = '0; rout_c = 1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (rin_a !== 1'b0) $display("FAIL reset ready_in a: got %b want 0", rin_a); else n_pass++;
      n_checks++; if (vout_a !== 1'b0) $display("FAIL reset valid_out a: got %b want 0", vout_a); else n_pass++;
      n_checks++; if (obs_a() !== e) $display("FAIL reset outputs a: got %h want %h", obs_a(), e); else n_pass++;
      n_checks++; if (rin_b !== 1'b0) $display("FAIL reset ready_in b: got %b want 0", rin_b); else n_pass++;
      n_checks++; if (vout_b !== 1'b0) $display("FAIL reset valid_out b: got %b want 0", vout_b); else n_pass++;
      n_checks++; if (obs_b() !== e) $display("FAIL reset outputs b: got %h want %h", obs_b(), e); else n_pass++;
      n_checks++; if (rin_c !== 1'b0) $display("FAIL reset ready_in c: got %b want 0", rin_c); else n_pass++;
      n_checks++; if (vout_c !== 1'b0) $display("FAIL reset valid_out c: got %b want 0", vout_c); else n_pass++;
      n_checks++; if (obs_c() !== e) $display("FAIL reset outputs c: got %h want %h", obs_c(), e); else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++; if (rin_a !== 1'b1) $display("FAIL idle ready_in a: got %b want 1", rin_a); else n_pass++;
   endtask

   task automatic test_single_lane();
      logic [7:0] m [1] = '{8'hA6};
      logic [3:0] t [1] = '{4'h5};
      beat_t exp_b, got_b;
      int si = 0, cyc = 0;
      bit acc = 0;
      @(negedge clk);
      while ((si < 1 || q_a.size() > 0) && cyc < 40) begin
         if (q_a.size() > 0) begin
            exp_b = q_a.pop_front(); got_b = obs_a();
            n_checks++;
            if (vout_a !== 1'b1 || got_b !== exp_b) $display("FAIL single_lane beat: valid=%b got %h want %h", vout_a, got_b, exp_b); else n_pass++;
            n_checks++;
            if (rin_a !== exp_b.last) $display("FAIL single_lane ready_in: got %b want %b", rin_a, exp_b.last); else n_pass++;
         end
         if (acc) si++;
         if (si < 1) begin vin_a = 1; din_a = m[si]; tin_a = t[si]; end else vin_a = 0;
         acc = vin_a && rin_a;
         if (acc) push_exp(0, m[si], t[si]);
         @(negedge clk); cyc++;
      end
      n_checks++;
      if (q_a.size() != 0 || vout_a !== 1'b0) $display("FAIL single_lane drain: pending=%0d valid=%b want 0/0", q_a.size(), vout_a); else n_pass++;
   endtask

   task automatic test_dual_lane();
      logic [7:0] m [2] = '{8'hA6, 8'h0B};
      logic [3:0] t [2] = '{4'h3, 4'h9};
      beat_t exp_b, got_b;
      int si = 0, cyc = 0;
      bit acc = 0;
      @(negedge clk);
      while ((si < 2 || q_b.size() > 0) && cyc < 40) begin
         if (q_b.size() > 0) begin
            exp_b = q_b.pop_front(); got_b = obs_b();
            n_checks++;
            if (vout_b !== 1'b1 || got_b !== exp_b) $display("FAIL dual_lane beat: valid=%b got %h want %h", vout_b, got_b, exp_b); else n_pass++;
            n_checks++;
            if (rin_b !== exp_b.last) $display("FAIL dual_lane ready_in: got %b want %b", rin_b, exp_b.last); else n_pass++;
         end
         if (acc) si++;
         if (si < 2) begin vin_b = 1; din_b = m[si]; tin_b = t[si]; end else vin_b = 0;
         acc = vin_b && rin_b;
         if (acc) push_exp(1, m[si], t[si]);
         @(negedge clk); cyc++;
      end
      n_checks++;
      if (q_b.size() != 0 || vout_b !== 1'b0) $display("FAIL dual_lane drain: pending=%0d valid=%b want 0/0", q_b.size(), vout_b); else n_pass++;
   endtask

   task automatic test_reverse();
      beat_t exp_b, got_b;
      int cyc = 0;
      @(negedge clk);
      vin_c = 1; din_c = 8'h81; tin_c = 4'hC;
      if (rin_c) push_exp(2, 8'h81, 4'hC);
      n_checks++;
      if (rin_c !== 1'b1) $display("FAIL reverse accept: ready_in got %b want 1", rin_c); else n_pass++;
      @(negedge clk);
      vin_c = 0;
      while (q_c.size() > 0 && cyc < 20) begin
         exp_b = q_c.pop_front(); got_b = obs_c();
         n_checks++;
         if (vout_c !== 1'b1 || got_b !== exp_b) $display("FAIL reverse beat: valid=%b got %h want %h", vout_c, got_b, exp_b); else n_pass++;
         @(negedge clk); cyc++;
      end
      n_checks++;
      if (vout_c !== 1'b0) $display("FAIL reverse idle: valid got %b want 0", vout_c); else n_pass++;
   endtask

   task automatic test_zero_mask();
      beat_t exp_b, got_b;
      int cyc = 0;
      @(negedge clk);
      vin_a = 1; din_a = 8'h00; tin_a = 4'h1;
      if (rin_a) push_exp(0, 8'h00, 4'h1);
      @(negedge clk);
      vin_a = 0;
      while (q_a.size() > 0 && cyc < 20) begin
         exp_b = q_a.pop_front(); got_b = obs_a();
         n_checks++;
         if (vout_a !== 1'b1 || got_b !== exp_b) $display("FAIL zero_mask beat: valid=%b got %h want %h", vout_a, got_b, exp_b); else n_pass++;
         @(negedge clk); cyc++;
      end
      n_checks++;
      if (q_a.size() != 0 || vout_a !== 1'b0) $display("FAIL zero_mask idle: pending=%0d valid=%b want 0/0", q_a.size(), vout_a); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] m [2] = '{8'h03, 8'h10};
      logic [3:0] t [2] = '{4'h1, 4'h2};
      beat_t exp_b, got_b;
      int si = 0, cyc = 0;
      bit acc = 0;
      @(negedge clk);
      while ((si < 2 || q_a.size() > 0) && cyc < 40) begin
         // Stall the consumer on the first beat; outputs must hold meanwhile.
         rout_a = !(cyc >= 1 && cyc <= 3);
         #1;
         if (q_a.size() > 0) begin
            exp_b = q_a[0]; got_b = obs_a();
            n_checks++;
            if (vout_a !== 1'b1 || got_b !== exp_b) $display("FAIL back_to_back beat cyc%0d: valid=%b got %h want %h", cyc, vout_a, got_b, exp_b); else n_pass++;
            if (rout_a) begin
               n_checks++;
               if (rin_a !== exp_b.last) $display("FAIL back_to_back ready_in: got %b want %b", rin_a, exp_b.last); else n_pass++;
               void'(q_a.pop_front());
            end
         end
         if (acc) si++;
         if (si < 2) begin vin_a = 1; din_a = m[si]; tin_a = t[si]; end else vin_a = 0;
         acc = vin_a && rin_a;
         if (acc) push_exp(0, m[si], t[si]);
         @(negedge clk); cyc++;
      end
      rout_a = 1;
      n_checks++;
      if (q_a.size() != 0 || vout_a !== 1'b0) $display("FAIL back_to_back drain: pending=%0d valid=%b want 0/0", q_a.size(), vout_a); else n_pass++;
   endtask

   task automatic test_reset_mid_mask();
      beat_t exp_b, got_b;
      @(negedge clk);
      vin_a = 1; din_a = 8'hFF; tin_a = 4'h6;
      push_exp(0, 8'hFF, 4'h6);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vin_a = 0;
         exp_b = q_a.pop_front(); got_b = obs_a();
         n_checks++;
         if (vout_a !== 1'b1 || got_b !== exp_b) $display("FAIL reset_mid beat%0d: valid=%b got %h want %h", i, vout_a, got_b, exp_b); else n_pass++;
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (rin_a !== 1'b0) $display("FAIL reset_mid ready_in during reset: got %b want 0", rin_a); else n_pass++;
      q_a.delete();
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (vout_a !== 1'b0) $display("FAIL reset_mid valid_out after reset: got %b want 0", vout_a); else n_pass++;
      n_checks++;
      if (rin_a !== 1'b1) $display("FAIL reset_mid ready_in after reset: got %b want 1", rin_a); else n_pass++;
      vin_a = 1; din_a = 8'h04; tin_a = 4'h7;
      push_exp(0, 8'h04, 4'h7);
      @(negedge clk);
      vin_a = 0;
      exp_b = q_a.pop_front(); got_b = obs_a();
      n_checks++;
      if (vout_a !== 1'b1 || got_b !== exp_b) $display("FAIL reset_mid new mask: valid=%b got %h want %h", vout_a, got_b, exp_b); else n_pass++;
      @(negedge clk);
      n_checks++;
      if (vout_a !== 1'b0) $display("FAIL reset_mid idle: valid got %b want 0", vout_a); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_lane();
      test_dual_lane();
      test_reverse();
      test_zero_mask();
      test_back_to_back();
      test_reset_mid_mask();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
